// File: rtl/znmi_mc_if.sv
// znmi_mc_if: bundle of request-source, Z80 bus and NMI control signals
// around the multi-source NMI controller.
//   master : request sources / Z80 side (drives strobes, requests, bus)
//   slave  : the controller (drives NMI pulse, NOP forcing, page mode)
// Signals:
//   zpos, zneg    Z80 clock rise/fall strobes (fclk domain)
//   int_start     one-fclk pulse at INT start
//   req, src_en   per-source request levels and capture enables
//   clr_nmi       one-fclk pulse, software exit request
//   rfsh_n, m1_n, mreq_n, a   Z80 bus
//   drive_00, in_nmi, gen_nmi, nmi_buf_clr, nmi_src, nmi_pend  controller outputs
interface znmi_mc_if #(
   parameter int NSRC = 4,
   parameter int IDW  = 3
);
   logic            zpos;
   logic            zneg;
   logic            int_start;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] src_en;
   logic            clr_nmi;
   logic            rfsh_n;
   logic            m1_n;
   logic            mreq_n;
   logic [15:0]     a;
   logic            drive_00;
   logic            in_nmi;
   logic            gen_nmi;
   logic            nmi_buf_clr;
   logic [IDW-1:0]  nmi_src;
   logic [NSRC-1:0] nmi_pend;

   modport master (
      output zpos, zneg, int_start, req, src_en, clr_nmi, rfsh_n, m1_n, mreq_n, a,
      input  drive_00, in_nmi, gen_nmi, nmi_buf_clr, nmi_src, nmi_pend
   );

   modport slave (
      input  zpos, zneg, int_start, req, src_en, clr_nmi, rfsh_n, m1_n, mreq_n, a,
      output drive_00, in_nmi, gen_nmi, nmi_buf_clr, nmi_src, nmi_pend
   );
endinterface

// File: rtl/znmi_mc.sv
// znmi_mc: multi-source NMI controller for the Z80 core.
// Latches rising edges of per-source request lines, arbitrates them by fixed
// priority (lowest index wins), fires immediately or at the next INT start
// depending on IMM_MASK, produces a PULSE_LEN-zpos NMI pulse, forces a NOP on
// the entry fetch and holds NMI page mode until software clears it and
// CLR_RFSH refresh cycles have passed.
// Ports:
//   fclk   system clock
//   rst_n  asynchronous active-low reset
//   bus    znmi_mc_if slave modport (sources, Z80 bus, controller outputs)
module znmi_mc #(
   parameter int              NSRC       = 4,
   parameter logic [NSRC-1:0] IMM_MASK   = 4'b1000,
   parameter int              PULSE_LEN  = 4,
   parameter logic [15:0]     ENTRY_ADDR = 16'h0066,
   parameter int              CLR_RFSH   = 2,
   parameter int              IDW        = 3
) (
   input  logic      fclk,
   input  logic      rst_n,
   znmi_mc_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ENTRY, ACTIVE, EXIT} state_t;

   state_t          state, state_nxt;

   logic [NSRC-1:0] req_r;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] edge_set;
   logic [NSRC-1:0] elig;
   logic [NSRC-1:0] clr_mask;
   logic            any_elig;
   logic [IDW-1:0]  win;
   logic [IDW-1:0]  src_r;

   logic [3:0]      pcnt;
   logic [1:0]      rcnt;

   logic            m1_r, mreq_r, was_m1, was_m1_d, last_entry;
   logic            rfsh_z, rfsh_d, rfsh_fall;
   logic            entry_hit;

   logic            start, rload, rdec;

   // ---------------- request capture ----------------
   // src_en only gates the capture of new edges; already pending bits stay.
   assign edge_set = bus.req & ~req_r & bus.src_en;
   assign clr_mask = start ? ({{(NSRC-1){1'b0}}, 1'b1} << win) : '0;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         req_r <= '0;
         pend  <= '0;
      end else begin
         req_r <= bus.req;
         // a fresh edge on the winning source in its start cycle is kept
         pend  <= (pend & ~clr_mask) | edge_set;
      end
   end

   // ---------------- arbitration ----------------
   // Non-immediate sources only qualify in an int_start cycle; pend is the
   // registered value, so an edge coinciding with int_start waits a frame.
   always_comb begin
      elig     = pend & (IMM_MASK | {NSRC{bus.int_start}});
      any_elig = |elig;
      win      = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (elig[i]) win = IDW'(i);
      end
   end

   // ---------------- Z80 bus tracking ----------------
   assign entry_hit = (bus.a == ENTRY_ADDR);
   assign was_m1    = ~(m1_r | mreq_r);
   assign rfsh_fall = rfsh_d & ~rfsh_z;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         m1_r       <= 1'b0;
         mreq_r     <= 1'b0;
         was_m1_d   <= 1'b0;
         last_entry <= 1'b0;
         rfsh_z     <= 1'b0;
         rfsh_d     <= 1'b0;
      end else begin
         if (bus.zpos) begin
            m1_r   <= bus.m1_n;
            rfsh_z <= bus.rfsh_n;
         end
         if (bus.zneg) mreq_r <= bus.mreq_n;
         rfsh_d   <= rfsh_z;
         was_m1_d <= was_m1;
         // remember whether the most recent opcode fetch was the NMI entry
         if (was_m1 && !was_m1_d) last_entry <= entry_hit;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      rload     = 1'b0;
      rdec      = 1'b0;
      case (state)
         IDLE: begin
            if (any_elig) begin
               start     = 1'b1;
               state_nxt = ENTRY;
            end
         end
         ENTRY: begin
            // clr_nmi deliberately has no effect until the entry fetch is done
            if (rfsh_fall && last_entry) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (bus.clr_nmi) begin
               rload     = 1'b1;
               state_nxt = EXIT;
            end
         end
         EXIT: begin
            if (bus.clr_nmi) begin
               rload = 1'b1;
            end else if (rfsh_fall) begin
               rdec = 1'b1;
               if (rcnt <= 2'd1) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- counters / source id ----------------
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt  <= '0;
         rcnt  <= '0;
         src_r <= '0;
      end else begin
         // load beats a coincident zpos so the pulse spans PULSE_LEN full strobes
         if (start)                         pcnt <= 4'(PULSE_LEN);
         else if (bus.zpos && pcnt != 4'd0) pcnt <= pcnt - 4'd1;

         if (rload)     rcnt <= 2'(CLR_RFSH);
         else if (rdec) rcnt <= rcnt - 2'd1;

         if (start) src_r <= win;
      end
   end

   // ---------------- outputs ----------------
   assign bus.gen_nmi     = (pcnt != 4'd0);
   assign bus.in_nmi      = (state == ACTIVE) || (state == EXIT);
   assign bus.drive_00    = (state == ENTRY) && !bus.m1_n && !bus.mreq_n && entry_hit;
   assign bus.nmi_buf_clr = (state == ENTRY) && last_entry;
   assign bus.nmi_src     = src_r;
   assign bus.nmi_pend    = pend;

endmodule

// File: tb/tb_znmi_mc.sv
// tb_znmi_mc: self-checking bench for znmi_mc. Table vectors from reset,
// hand-written multi-cycle sequences, and randomized NMI episodes checked
// against a pending-set / priority model held in the bench.
module tb_znmi_mc;
   localparam int         NSRC = 4;
   localparam int         IDW  = 3;
   localparam logic [3:0] IMM  = 4'b1000;
   localparam int         PLEN = 4;

   logic fclk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   znmi_mc_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

   znmi_mc #(
      .NSRC(NSRC), .IMM_MASK(IMM), .PULSE_LEN(PLEN),
      .ENTRY_ADDR(16'h0066), .CLR_RFSH(2), .IDW(IDW)
   ) dut (
      .fclk(fclk), .rst_n(rst_n), .bus(bus)
   );

   initial begin
      fclk = 1'b0;
      forever #5 fclk = ~fclk;
   end

   // Z80 clock strobes: one zpos and one zneg every 4 fclk
   logic [1:0] zph;
   initial begin
      zph = 2'd0; bus.zpos = 1'b0; bus.zneg = 1'b0;
      forever begin
         @(posedge fclk); #1;
         zph      = zph + 2'd1;
         bus.zpos = (zph == 2'd0);
         bus.zneg = (zph == 2'd2);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge fclk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req = '0; bus.src_en = '1; bus.int_start = 1'b0; bus.clr_nmi = 1'b0;
      bus.rfsh_n = 1'b1; bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.a = '0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic pulse_req(input logic [3:0] m, input logic [3:0] en);
      bus.src_en = en; bus.req = m;
      cyc();
      bus.req = '0;
   endtask

   task automatic pulse_int();
      bus.int_start = 1'b1; cyc(); bus.int_start = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.clr_nmi = 1'b1; cyc(); bus.clr_nmi = 1'b0;
   endtask

   // opcode fetch: M1 and MREQ low for len fclk, then released
   task automatic m1_cycle(input logic [15:0] addr, input int len, output logic d00, output logic bclr);
      bus.a = addr; bus.m1_n = 1'b0; bus.mreq_n = 1'b0;
      d00 = 1'b0; bclr = 1'b0;
      repeat (len) begin
         @(negedge fclk);
         d00  = d00 | bus.drive_00;
         bclr = bus.nmi_buf_clr;
         @(posedge fclk); #1;
      end
      bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.a = 16'h00ff;
   endtask

   task automatic rfsh_pulse();
      bus.rfsh_n = 1'b0; cyc(8);
      bus.rfsh_n = 1'b1; cyc(8);
   endtask

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return -1;
   endfunction

   typedef struct {
      logic [3:0] req;
      logic [3:0] en;
      bit         use_int;
      logic       exp_gen;
      logic [2:0] exp_src;
      logic [3:0] exp_pend;
   } vec_t;

   vec_t        tbl [8];
   logic        d00, bclr, seen;
   logic [3:0]  m, e, mpend;
   logic [15:0] addr;
   int          w, n;

   initial begin
      tbl[0] = '{4'b0001, 4'b1111, 1'b0, 1'b0, 3'd0, 4'b0001};
      tbl[1] = '{4'b0001, 4'b1111, 1'b1, 1'b1, 3'd0, 4'b0000};
      tbl[2] = '{4'b1000, 4'b1111, 1'b0, 1'b1, 3'd3, 4'b0000};
      tbl[3] = '{4'b0110, 4'b1111, 1'b1, 1'b1, 3'd1, 4'b0100};
      tbl[4] = '{4'b0100, 4'b1011, 1'b1, 1'b0, 3'd0, 4'b0000};
      tbl[5] = '{4'b1001, 4'b1111, 1'b0, 1'b1, 3'd3, 4'b0001};
      tbl[6] = '{4'b1111, 4'b0111, 1'b1, 1'b1, 3'd0, 4'b0110};
      tbl[7] = '{4'b1010, 4'b1111, 1'b1, 1'b1, 3'd3, 4'b0010};

      // reset state, sampled while reset is held
      rst_n = 1'b0;
      bus.req = '0; bus.src_en = '1; bus.int_start = 1'b0; bus.clr_nmi = 1'b0;
      bus.rfsh_n = 1'b1; bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.a = '0;
      cyc(2);
      @(negedge fclk);
      chk("rst_gen",  bus.gen_nmi, 0);
      chk("rst_in",   bus.in_nmi, 0);
      chk("rst_d00",  bus.drive_00, 0);
      chk("rst_bclr", bus.nmi_buf_clr, 0);
      chk("rst_src",  bus.nmi_src, 0);
      chk("rst_pend", bus.nmi_pend, 0);

      // table vectors, each from reset
      for (int k = 0; k < 8; k++) begin
         do_reset();
         pulse_req(tbl[k].req, tbl[k].en);
         cyc();
         if (tbl[k].use_int) pulse_int(); else cyc();
         @(negedge fclk);
         chk($sformatf("vec%0d_gen", k),  bus.gen_nmi,  tbl[k].exp_gen);
         chk($sformatf("vec%0d_src", k),  bus.nmi_src,  tbl[k].exp_src);
         chk($sformatf("vec%0d_pend", k), bus.nmi_pend, tbl[k].exp_pend);
      end

      // deferred source, pulse length in zpos strobes
      do_reset();
      pulse_req(4'b0001, 4'b1111);
      cyc(39);
      @(negedge fclk);
      chk("h1_wait_gen", bus.gen_nmi, 0);
      bus.int_start = 1'b1;
      @(negedge fclk);
      bus.int_start = 1'b0;
      chk("h1_gen_rise", bus.gen_nmi, 1);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.gen_nmi && bus.zpos) n++;
         @(negedge fclk);
      end
      chk("h1_zpos_cnt", 32'(n), 32'(PLEN));
      chk("h1_gen_end", bus.gen_nmi, 0);
      chk("h1_src", bus.nmi_src, 0);
      chk("h1_pend", bus.nmi_pend, 0);

      // immediate source and entry fetch
      do_reset();
      pulse_req(4'b1000, 4'b1111);
      cyc();
      @(negedge fclk);
      chk("h2_gen", bus.gen_nmi, 1);
      chk("h2_src", bus.nmi_src, 3);
      m1_cycle(16'h0066, 8, d00, bclr);
      chk("h2_d00", d00, 1);
      chk("h2_bclr", bclr, 1);
      chk("h2_in_pre", bus.in_nmi, 0);
      rfsh_pulse();
      @(negedge fclk);
      chk("h2_in", bus.in_nmi, 1);
      chk("h2_bclr_off", bus.nmi_buf_clr, 0);
      chk("h2_d00_off", bus.drive_00, 0);

      // priority, exit after two refreshes, then next source
      do_reset();
      pulse_req(4'b0110, 4'b1111);
      cyc();
      pulse_int();
      @(negedge fclk);
      chk("h3_src1", bus.nmi_src, 1);
      chk("h3_pend", bus.nmi_pend, 4'b0100);
      m1_cycle(16'h0066, 8, d00, bclr);
      rfsh_pulse();
      chk("h3_in", bus.in_nmi, 1);
      pulse_clr();
      rfsh_pulse();
      @(negedge fclk);
      chk("h3_exit1", bus.in_nmi, 1);
      rfsh_pulse();
      @(negedge fclk);
      chk("h3_exit2", bus.in_nmi, 0);
      chk("h3_gen_idle", bus.gen_nmi, 0);
      pulse_int();
      @(negedge fclk);
      chk("h3_src2", bus.nmi_src, 2);
      chk("h3_gen2", bus.gen_nmi, 1);
      chk("h3_pend2", bus.nmi_pend, 0);

      // clr_nmi ignored in ENTRY, reload in EXIT
      do_reset();
      pulse_req(4'b0001, 4'b1111);
      cyc();
      pulse_int();
      pulse_clr();
      m1_cycle(16'h0066, 8, d00, bclr);
      rfsh_pulse();
      @(negedge fclk);
      chk("h4_in", bus.in_nmi, 1);
      pulse_clr();
      rfsh_pulse();
      pulse_clr();
      rfsh_pulse();
      @(negedge fclk);
      chk("h4_reload", bus.in_nmi, 1);
      rfsh_pulse();
      @(negedge fclk);
      chk("h4_exit", bus.in_nmi, 0);

      // src_en gating and pend/int_start same-cycle rule
      do_reset();
      pulse_req(4'b0100, 4'b1011);
      cyc();
      pulse_int();
      @(negedge fclk);
      chk("h5_dis_pend", bus.nmi_pend, 0);
      chk("h5_dis_gen", bus.gen_nmi, 0);
      pulse_req(4'b0001, 4'b1111);
      bus.src_en = 4'b1110;
      cyc();
      pulse_int();
      @(negedge fclk);
      chk("h5_kept_gen", bus.gen_nmi, 1);
      chk("h5_kept_src", bus.nmi_src, 0);
      do_reset();
      bus.req = 4'b0010; bus.int_start = 1'b1;
      cyc();
      bus.req = '0; bus.int_start = 1'b0;
      cyc();
      @(negedge fclk);
      chk("h5_same_gen", bus.gen_nmi, 0);
      chk("h5_same_pend", bus.nmi_pend, 4'b0010);
      pulse_int();
      @(negedge fclk);
      chk("h5_next_src", bus.nmi_src, 1);
      chk("h5_next_gen", bus.gen_nmi, 1);

      // asynchronous reset in ACTIVE while the pulse is still running
      do_reset();
      pulse_req(4'b1000, 4'b1111);
      cyc();
      m1_cycle(16'h0066, 4, d00, bclr);
      bus.rfsh_n = 1'b0;
      cyc(5);
      @(negedge fclk);
      chk("h6_pre_gen", bus.gen_nmi, 1);
      chk("h6_pre_in", bus.in_nmi, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("h6_rst_gen", bus.gen_nmi, 0);
      chk("h6_rst_in", bus.in_nmi, 0);
      chk("h6_rst_d00", bus.drive_00, 0);
      chk("h6_rst_src", bus.nmi_src, 0);
      do_reset();
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k % 10 == 0) pulse_int(); else cyc();
         @(negedge fclk);
         seen = seen | bus.gen_nmi;
      end
      chk("h6_no_nmi", seen, 0);
      chk("h6_no_pend", bus.nmi_pend, 0);

      // randomized episodes against a pending-set model
      do_reset();
      mpend = '0;
      for (int ep = 0; ep < 25; ep++) begin
         m = 4'($urandom_range(0, 15));
         e = 4'($urandom_range(0, 15));
         pulse_req(m, e);
         mpend = mpend | (m & e);
         cyc();
         if ((mpend & IMM) != 4'b0) begin
            w = lowest(mpend & IMM);
         end else begin
            pulse_int();
            w = lowest(mpend);
         end
         @(negedge fclk);
         if (w < 0) begin
            chk($sformatf("rnd%0d_idle_gen", ep), bus.gen_nmi, 0);
            chk($sformatf("rnd%0d_idle_pend", ep), bus.nmi_pend, mpend);
            continue;
         end
         mpend[w] = 1'b0;
         chk($sformatf("rnd%0d_gen", ep), bus.gen_nmi, 1);
         chk($sformatf("rnd%0d_src", ep), bus.nmi_src, 32'(w));
         chk($sformatf("rnd%0d_pend", ep), bus.nmi_pend, mpend);
         if ($urandom_range(0, 2) == 0) begin
            addr = 16'($urandom_range(0, 65535));
            if (addr == 16'h0066) addr = 16'h0067;
            m1_cycle(addr, 8, d00, bclr);
            rfsh_pulse();
            chk($sformatf("rnd%0d_stray_d00", ep), d00, 0);
            chk($sformatf("rnd%0d_stray_in", ep), bus.in_nmi, 0);
         end
         m1_cycle(16'h0066, 8, d00, bclr);
         chk($sformatf("rnd%0d_d00", ep), d00, 1);
         rfsh_pulse();
         chk($sformatf("rnd%0d_in", ep), bus.in_nmi, 1);
         // requests while busy stay pending (deferred sources only)
         m = 4'($urandom_range(0, 7));
         e = 4'($urandom_range(0, 15));
         pulse_req(m, e);
         mpend = mpend | (m & e);
         cyc();
         @(negedge fclk);
         chk($sformatf("rnd%0d_busy_pend", ep), bus.nmi_pend, mpend);
         pulse_clr();
         rfsh_pulse();
         chk($sformatf("rnd%0d_exit1", ep), bus.in_nmi, 1);
         rfsh_pulse();
         @(negedge fclk);
         chk($sformatf("rnd%0d_exit2", ep), bus.in_nmi, 0);
         chk($sformatf("rnd%0d_end_pend", ep), bus.nmi_pend, mpend);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/znmi_mc.md
Name: znmi_mc

Overview:
- Multi-source NMI controller for the Z80 core, sitting between the NMI request sources (slavespi, port #BF, breakpoint unit, future sources) and the Z80 NMI_N pin / zmem page logic.
- Latches per-source requests and arbitrates them by fixed priority.
- Each source either waits for the next INT start or fires immediately, selected per source.
- Generates a programmable-length NMI pulse, forces a NOP on the entry fetch, and holds NMI page mode until software clears it.

Parameters:
- NSRC, 4, number of request channels (1..8).
- IMM_MASK, 4'b1000, bit i=1 means source i starts immediately; bit i=0 means it waits for int_start.
- PULSE_LEN, 4, number of zpos strobes gen_nmi stays high (1..15).
- ENTRY_ADDR, 16'h0066, M1 address treated as the NMI entry fetch.
- CLR_RFSH, 2, refresh cycles after clr_nmi before in_nmi drops (1..3).
- IDW, 3, width of nmi_src; must satisfy 2^IDW >= NSRC.

Ports:
- fclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- zpos  in  1  Z80 clock rising-edge strobe (fclk domain)
- zneg  in  1  Z80 clock falling-edge strobe
- int_start  in  1  one-fclk pulse at INT start
- req  in  NSRC  request levels; rising edge = request
- src_en  in  NSRC  per-source enable, gates edge capture only
- clr_nmi  in  1  one-fclk pulse from out to #xxBE
- rfsh_n  in  1  Z80 RFSH_N
- m1_n  in  1  Z80 M1_N
- mreq_n  in  1  Z80 MREQ_N
- a  in  16  Z80 address bus
- drive_00  out  1  drive #00 (NOP) onto the Z80 data bus
- in_nmi  out  1  NMI page mode (#FF RAM page at 0000-3FFF)
- gen_nmi  out  1  1 = pull NMI_N low
- nmi_buf_clr  out  1  clear zmem read buffer during entry
- nmi_src  out  IDW  index of the source that started the last NMI
- nmi_pend  out  NSRC  pending request bits

Behaviour:
- Reset: all registers 0; state IDLE; all outputs 0; req edge history loaded with 0.
- Edge capture: req is registered each fclk. A rising edge on bit i with src_en[i]=1 sets pend[i] on the next fclk. pend[i] clears only when source i is serviced. The pending bits are not cleared by int_start. nmi_pend = pend.
- Eligible sources, evaluated only in IDLE:
  - pend[i] & IMM_MASK[i] at any cycle;
  - pend[i] & ~IMM_MASK[i] only in a cycle where int_start=1.
  - The lowest eligible index wins.
  - A pend bit set in the same cycle as int_start is not eligible until the next int_start, because pend is registered.
- Start (one fclk, from IDLE): pend[winner] is cleared, nmi_src is set to the winner, the pulse counter is loaded with PULSE_LEN, and the state goes to ENTRY.
- Pulse: gen_nmi = (pulse counter != 0). The counter decrements on each zpos. gen_nmi is therefore high for PULSE_LEN zpos strobes from the start cycle.
- Bus tracking:
  - m1_n is sampled on zpos; mreq_n is sampled on zneg.
  - was_m1 = ~(m1_r | mreq_r).
  - On the rising edge of was_m1, last_entry is loaded with (a==ENTRY_ADDR).
  - rfsh_n is sampled on zpos and registered once more on fclk.
  - rfsh_fall = previous high & current low.
- ENTRY:
  - drive_00 = !m1_n & !mreq_n & (a==ENTRY_ADDR). This term is combinational and is active only in ENTRY.
  - nmi_buf_clr = last_entry.
  - On rfsh_fall with last_entry=1: state goes to ACTIVE and in_nmi is set to 1.
  - clr_nmi is ignored in ENTRY.
- ACTIVE: in_nmi=1. clr_nmi loads the refresh counter with CLR_RFSH; state goes to EXIT.
- EXIT:
  - Each rfsh_fall decrements the refresh counter.
  - When the counter reaches 0: in_nmi is set to 0 and state goes to IDLE in the same fclk.
  - A further clr_nmi in EXIT reloads the counter with CLR_RFSH.
- Requests arriving while the state is not IDLE stay pending and are arbitrated on return to IDLE. There is no nesting.
- Disabling a source (src_en=0) does not clear an already-pending bit.
- Asynchronous reset mid-operation (any state) returns to IDLE immediately. gen_nmi, in_nmi and drive_00 drop at once.

Test Plan:
1. req[0] rising edge (IMM_MASK[0]=0), then int_start 40 fclk later -> gen_nmi rises the fclk after int_start; it is high for exactly 4 zpos; nmi_src=0; pend[0]=0.
2. req[3] rising edge (immediate) -> gen_nmi within 2 fclk with no int_start. Drive M1 at #0066: drive_00=1 during M1&MREQ; in_nmi=1 on the following rfsh fall; nmi_buf_clr=1 from M1 until that point.
3. req[1] and req[2] edges, then int_start -> source 1 is serviced (nmi_src=1) and pend=4'b0100. After clr_nmi plus 2 refresh falls, in_nmi=0. The next int_start then starts source 2.
4. clr_nmi in ENTRY -> ignored, in_nmi still goes to 1. clr_nmi in ACTIVE, then a second clr_nmi after 1 refresh fall -> in_nmi stays 1 until 2 more refresh falls.
5. Edge on req[2] with src_en[2]=0 -> pend stays 0 and gen_nmi stays 0. Set pend[0], then drive src_en[0]=0 -> still serviced at int_start.
6. rst_n low while in ACTIVE with gen_nmi=1 -> all outputs 0 asynchronously. After release, no NMI occurs without a new request edge.
